// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder
// Memory-side responder for the MEM-stage data interface. Accepts one load or
// store at a time, waits a fixed number of cycles, then presents the result on
// a valid/ready response channel. Misaligned or unmapped addresses raise
// rsp_err and never touch the backing array.

module mips_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  // The first WAIT cycle already counts as one wait cycle, hence LATENCY-1.
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        accept;
  logic        enter_resp;
  logic        consume;

  logic        chk_we;
  logic [31:0] chk_addr;
  logic [31:0] chk_wdata;
  logic        borrow;
  logic [31:0] offset;
  logic        chk_err;
  logic [AW-1:0] chk_idx;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE);

  // With LATENCY==0 the request goes straight to RESP on its accepting edge,
  // so the check must look at the live request instead of the latched copy.
  assign chk_we    = (state == IDLE) ? req_we    : lat_we;
  assign chk_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign chk_wdata = (state == IDLE) ? req_wdata : lat_wdata;

  // A 33-bit subtract gives the below-base borrow without a separate compare,
  // so an address below BASE_ADDR is flagged instead of wrapping into range.
  assign {borrow, offset} = {1'b0, chk_addr} - {1'b0, BASE_ADDR};
  assign chk_err = (offset[1:0] != 2'b00) || (offset[31:AW+2] != '0) || borrow;
  assign chk_idx = offset[AW+1:2];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the single-cycle event strobes that drive the datapath.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            next_state = RESP;
            enter_resp = 1'b1;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          next_state = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
          consume    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else if (accept) begin
      cnt       <= CNT_INIT;
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response registers: loaded on RESP entry, held until the initiator consumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_valid <= 1'b1;
      rsp_err   <= chk_err;
      rsp_rdata <= (!chk_we && !chk_err) ? mem[chk_idx] : 32'd0;
    end else if (consume) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end
  end

  // Backing array is deliberately not reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (enter_resp && chk_we && !chk_err) begin
      mem[chk_idx] <= chk_wdata;
    end
  end

endmodule
